// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states and owner ids.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one instruction/data memory between the core access path
// and the loader/debug port. One access in flight at a time; reads wait out
// the memory latency, and the owner gets a one-cycle acknowledge.
//
// Handshake: a requester holds req (with we/addr/wdata) high until it sees
// its ack for one cycle. Request fields are latched at grant, so changes or a
// dropped req after the grant do not affect the transaction in flight.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  input  logic          ldr_lock,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(MEM_LAT + 1);

  state_t        r_state;
  logic          r_owner;
  logic          r_last;
  logic          r_we;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_ldr_rdata;

  logic          w_cpu_elig;
  logic          w_ldr_elig;
  logic          w_any;
  logic          w_grant;
  logic          w_sel_we;

  // Round-robin pick: on a tie, the requester not granted last wins.
  function automatic logic rr_pick(input logic cpu_e, input logic ldr_e,
                                   input logic last);
    if (cpu_e && ldr_e) return ~last;
    if (ldr_e)          return OWN_LDR;
    return OWN_CPU;
  endfunction

  assign w_cpu_elig = cpu_req & ~ldr_lock;
  assign w_ldr_elig = ldr_req;
  assign w_any      = w_cpu_elig | w_ldr_elig;
  assign w_grant    = rr_pick(w_cpu_elig, w_ldr_elig, r_last);
  assign w_sel_we   = (w_grant == OWN_LDR) ? ldr_we : cpu_we;

  // Read data passes straight through during RESP so it lines up with the
  // ack; afterwards the captured copy is held until the next read by that owner.
  assign cpu_rdata = (r_state == ST_RESP && r_owner == OWN_CPU) ? mem_rdata : r_cpu_rdata;
  assign ldr_rdata = (r_state == ST_RESP && r_owner == OWN_LDR) ? mem_rdata : r_ldr_rdata;

  assign cpu_stall = ldr_lock | (cpu_req & ~cpu_ack);
  assign dbg_state = r_state;

  // Arbitration FSM with registered memory strobes and acknowledges.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_CPU;
      r_last      <= OWN_CPU;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
      cpu_ack     <= 1'b0;
      ldr_ack     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      mem_we  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner   <= w_grant;
            r_we      <= w_sel_we;
            mem_addr  <= (w_grant == OWN_LDR) ? ldr_addr  : cpu_addr;
            mem_wdata <= (w_grant == OWN_LDR) ? ldr_wdata : cpu_wdata;
            // Write strobe and write ack both land in the ACCESS cycle.
            mem_we    <= w_sel_we;
            if (w_sel_we) begin
              if (w_grant == OWN_CPU) cpu_ack <= 1'b1;
              else                    ldr_ack <= 1'b1;
            end
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_we) begin
            r_last  <= r_owner;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= CW'(MEM_LAT - 1);
            if (MEM_LAT == 1) begin
              if (r_owner == OWN_CPU) cpu_ack <= 1'b1;
              else                    ldr_ack <= 1'b1;
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Counter reaches zero on this edge: next cycle is RESP.
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) begin
            if (r_owner == OWN_CPU) cpu_ack <= 1'b1;
            else                    ldr_ack <= 1'b1;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (r_owner == OWN_CPU) r_cpu_rdata <= mem_rdata;
          else                    r_ldr_rdata <= mem_rdata;
          r_last  <= r_owner;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified instruction/data memory of the multicycle core between two requesters: the core's memory-access path (fetch and load/store, address selected by IorD) and the program loader/debug port. Sits between the control unit/datapath and the memory macro. Grants one access at a time, sequences the memory read latency, and returns a per-requester acknowledge. Drives a stall to the control FSM so it holds its state while memory is busy or reserved by the loader.

## Interface
- AW, 32, address width (byte address, forwarded unchanged)
- DW, 32, data width
- MEM_LAT, 1, memory read latency in cycles (≥1); rdata valid MEM_LAT cycles after address presented
- CLK  in  1  clock, all state on rising edge
- CLR  in  1  reset, synchronous, active-high
- cpu_req  in  1  core access request, held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  core address
- cpu_wdata  in  DW  core write data
- cpu_rdata  out  DW  read data, valid when cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  control FSM must hold state
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack  same as cpu_*, loader side
- ldr_lock  in  1  loader reserves memory; core requests not granted while high
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_we  out  1  memory write strobe
- mem_rdata  in  DW  memory read data

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: evaluate requests. Only one requesting → grant it. Both → round-robin: grant the one not granted last. ldr_lock=1 → only loader eligible. Latch we/addr/wdata and owner; go ACCESS.
- ACCESS: drive mem_addr/mem_wdata from latch; mem_we = latched we for exactly this cycle. Write: pulse owner ack, go IDLE. Read: load latency counter with MEM_LAT−1; go RESP if MEM_LAT=1, else WAIT.
- WAIT: keep mem_addr; decrement counter; at 0 go RESP.
- RESP: capture mem_rdata into owner's rdata register, pulse owner ack, update last-grant, go IDLE.
- Counter width $clog2(MEM_LAT+1); no wrap.
- cpu_stall = ldr_lock | (cpu_req & ~cpu_ack).
- Non-owner rdata register keeps its previous value.

## Timing
- Reset values: state IDLE, cpu_ack=ldr_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=ldr_rdata=0, last-grant=CPU (loader wins first tie), counter=0.
- Request sampled in IDLE at edge t → ACCESS in cycle t+1.
- Write: mem_we and ack both in cycle t+1; latency 1 cycle.
- Read: ack + rdata in cycle t+1+MEM_LAT.
- Return to IDLE the cycle after ack; max throughput one access per 2 (write) or 2+MEM_LAT (read) cycles.
- Requester dropping req mid-transaction: transaction still completes and acks.
- Request inputs changing after grant are ignored (latched values used).
- ldr_lock rising during a core transaction: core transaction completes, next grant is loader.
- ldr_lock with ldr_req low: memory idles; core stalled.
- CLR mid-transaction: next edge forces reset values; in-flight write never re-issued, no ack emitted.

## Structure
- Shared package: state encoding localparams (IDLE/ACCESS/WAIT/RESP), owner encoding (OWN_CPU=0, OWN_LDR=1).
- Single module, no sub-modules; round-robin grant is a small combinational function inside.

## Test plan
- Core read, MEM_LAT=1, addr 0x0000_0010, memory holds 0x2008_0005 → mem_addr=0x10 in t+1, cpu_ack and cpu_rdata=0x2008_0005 in t+2, cpu_stall high t..t+1, low t+2.
- Loader write addr 0x40 data 0xDEAD_BEEF → mem_we=1 for one cycle in t+1, ldr_ack in t+1; subsequent core read of 0x40 returns 0xDEAD_BEEF.
- Simultaneous cpu/ldr reads after reset → loader granted first, core second; core ack 3 cycles after loader ack (MEM_LAT=1).
- ldr_lock=1 with cpu_req held 20 cycles → no cpu_ack, cpu_stall=1 throughout; drop lock → core granted at next IDLE.
- MEM_LAT=3 core read → ack exactly 4 cycles after request sampled; mem_addr stable across ACCESS/WAIT.
- CLR asserted in WAIT → next cycle all outputs at reset values, no ack; new request then served normally.
